// File: rtl/mc_request_assembler_pkg.sv
// mc_request_assembler_pkg: shared types and defaults for the memory-controller request entry stage
package mc_request_assembler_pkg;

    localparam int MC_ADDRWIDTH = 32;
    localparam int MC_IDWIDTH   = 4;
    localparam int MC_USERWIDTH = 4;
    localparam int MC_DATAWIDTH = 64;
    localparam int MC_BURSTLEN  = 4;
    localparam int MC_WDEPTH    = 8;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        WR_REQ,
        WR_DATA
    } mc_state_t;

endpackage

// File: rtl/mc_sync_fifo.sv
// mc_sync_fifo: single-clock FIFO with registered occupancy count and full/empty flags
module mc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_fire;
    logic             rd_fire;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // pointers and occupancy; simultaneous push and pop both take effect
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
            if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_fire) - (AW+1)'(rd_fire);
        end
    end

    // storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mc_request_assembler.sv
// mc_request_assembler: serializes AR and AW+W bursts into one fair, one-at-a-time request stream
module mc_request_assembler
    import mc_request_assembler_pkg::*;
#(
    parameter int ADDRWIDTH = MC_ADDRWIDTH,
    parameter int IDWIDTH   = MC_IDWIDTH,
    parameter int USERWIDTH = MC_USERWIDTH,
    parameter int DATAWIDTH = MC_DATAWIDTH,
    parameter int BURSTLEN  = MC_BURSTLEN,
    parameter int WDEPTH    = MC_WDEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ar_valid,
    output logic                   ar_ready,
    input  logic [ADDRWIDTH-1:0]   ar_addr,
    input  logic [IDWIDTH-1:0]     ar_id,
    input  logic [USERWIDTH-1:0]   ar_user,
    input  logic                   aw_valid,
    output logic                   aw_ready,
    input  logic [ADDRWIDTH-1:0]   aw_addr,
    input  logic [IDWIDTH-1:0]     aw_id,
    input  logic [USERWIDTH-1:0]   aw_user,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [DATAWIDTH-1:0]   w_data,
    input  logic [DATAWIDTH/8-1:0] w_strb,
    input  logic                   w_last,
    output logic                   req_valid,
    input  logic                   req_ready,
    output logic                   req_write,
    output logic [ADDRWIDTH-1:0]   req_addr,
    output logic [IDWIDTH-1:0]     req_id,
    output logic [USERWIDTH-1:0]   req_user,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic [DATAWIDTH-1:0]   data,
    output logic [DATAWIDTH/8-1:0] strb,
    output logic                   data_last,
    output logic                   proto_err
);

    localparam int SW     = DATAWIDTH / 8;
    localparam int NBURST = WDEPTH / BURSTLEN;
    localparam int BW     = $clog2(NBURST + 1);
    localparam int CW     = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURSTLEN - 1);
    localparam logic [BW-1:0] MAX_BURST = BW'(NBURST);

    mc_state_t               state;
    mc_state_t               state_nx;
    req_type_t               last_grant;
    logic                    ar_full;
    logic                    aw_full;
    logic [ADDRWIDTH-1:0]    ar_addr_q;
    logic [IDWIDTH-1:0]      ar_id_q;
    logic [USERWIDTH-1:0]    ar_user_q;
    logic [ADDRWIDTH-1:0]    aw_addr_q;
    logic [IDWIDTH-1:0]      aw_id_q;
    logic [USERWIDTH-1:0]    aw_user_q;
    logic [BW-1:0]           bursts_avail;
    logic [CW-1:0]           in_cnt;
    logic [CW-1:0]           out_cnt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATAWIDTH+SW-1:0] fifo_rd;
    logic                    w_fire;
    logic                    req_fire;
    logic                    data_fire;
    logic                    burst_in;
    logic                    burst_out;
    logic                    rd_elig;
    logic                    wr_elig;

    assign ar_ready  = !ar_full;
    assign aw_ready  = !aw_full;
    assign w_ready   = !fifo_full;
    assign w_fire    = w_valid && w_ready;
    assign req_fire  = req_valid && req_ready;
    assign data_fire = data_valid && data_ready;
    assign burst_in  = w_fire && w_last && bursts_avail != MAX_BURST;
    assign burst_out = data_fire && data_last;
    assign rd_elig   = ar_full;
    assign wr_elig   = aw_full && bursts_avail != '0;

    mc_sync_fifo #(
        .WIDTH (DATAWIDTH + SW),
        .DEPTH (WDEPTH)
    ) u_wfifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_valid),
        .wr_data ({w_data, w_strb}),
        .rd_en   (data_fire),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // AR/AW holding registers: a full register refuses input until its request is dispatched
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_full   <= 1'b0;
            aw_full   <= 1'b0;
            ar_addr_q <= '0;
            ar_id_q   <= '0;
            ar_user_q <= '0;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            aw_user_q <= '0;
        end else begin
            if (ar_valid && ar_ready) begin
                ar_full   <= 1'b1;
                ar_addr_q <= ar_addr;
                ar_id_q   <= ar_id;
                ar_user_q <= ar_user;
            end else if (state == RD_REQ && req_ready) begin
                ar_full <= 1'b0;
            end
            if (aw_valid && aw_ready) begin
                aw_full   <= 1'b1;
                aw_addr_q <= aw_addr;
                aw_id_q   <= aw_id;
                aw_user_q <= aw_user;
            end else if (state == WR_REQ && req_ready) begin
                aw_full <= 1'b0;
            end
        end
    end

    // beat bookkeeping on both sides of the W FIFO plus the sticky burst-length check
    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt       <= '0;
            out_cnt      <= '0;
            bursts_avail <= '0;
            proto_err    <= 1'b0;
        end else begin
            if (w_fire) begin
                in_cnt <= (w_last || in_cnt == LAST_BEAT) ? '0 : in_cnt + CW'(1);
                if (w_last != (in_cnt == LAST_BEAT)) proto_err <= 1'b1;
            end
            if (data_fire) out_cnt <= data_last ? '0 : out_cnt + CW'(1);
            bursts_avail <= bursts_avail + BW'(burst_in) - BW'(burst_out);
        end
    end

    // state register and fairness memory; the first tie after reset goes to a read
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= WRITE;
        end else begin
            state <= state_nx;
            if (req_fire) last_grant <= req_write ? WRITE : READ;
        end
    end

    // next-state and request/data outputs; all fields read zero when not valid
    always_comb begin
        state_nx   = state;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_id     = '0;
        req_user   = '0;
        data_valid = 1'b0;
        data_last  = 1'b0;
        data       = '0;
        strb       = '0;
        case (state)
            IDLE: begin
                state_nx = (rd_elig && wr_elig) ? ((last_grant == WRITE) ? RD_REQ : WR_REQ) :
                           rd_elig ? RD_REQ : wr_elig ? WR_REQ : IDLE;
            end
            RD_REQ: begin
                req_valid = 1'b1;
                req_addr  = ar_addr_q;
                req_id    = ar_id_q;
                req_user  = ar_user_q;
                state_nx  = req_ready ? IDLE : RD_REQ;
            end
            WR_REQ: begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = aw_addr_q;
                req_id    = aw_id_q;
                req_user  = aw_user_q;
                state_nx  = req_ready ? WR_DATA : WR_REQ;
            end
            WR_DATA: begin
                data_valid    = !fifo_empty;
                data_last     = data_valid && out_cnt == LAST_BEAT;
                {data, strb}  = data_valid ? fifo_rd : '0;
                state_nx      = (data_valid && data_ready && data_last) ? IDLE : WR_DATA;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_request_assembler.sv
// tb_mc_request_assembler: directed self-checking bench for the request assembler
module tb_mc_request_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id, ar_user;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id, aw_user;
    logic        w_valid, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        w_last;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_id, req_user;
    logic        data_valid, data_ready, data_last;
    logic [63:0] data;
    logic [7:0]  strb;
    logic        proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_request_assembler dut (
        .clk        (clk),
        .rst        (rst),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_id      (ar_id),
        .ar_user    (ar_user),
        .aw_valid   (aw_valid),
        .aw_ready   (aw_ready),
        .aw_addr    (aw_addr),
        .aw_id      (aw_id),
        .aw_user    (aw_user),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_strb     (w_strb),
        .w_last     (w_last),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_id     (req_id),
        .req_user   (req_user),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .strb       (strb),
        .data_last  (data_last),
        .proto_err  (proto_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ar_valid = 1'b0; ar_addr = '0; ar_id = '0; ar_user = '0;
        aw_valid = 1'b0; aw_addr = '0; aw_id = '0; aw_user = '0;
        w_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
        req_ready = 1'b0; data_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic l);
        w_valid = 1'b1; w_data = d; w_strb = 8'hFF; w_last = l;
        tick();
        w_valid = 1'b0; w_last = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [3:0] id);
        ar_valid = 1'b1; ar_addr = a; ar_id = id;
        tick();
        ar_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        gw [4];
        logic [31:0] ga [4];
        int ar_i, aw_i, g, a_f, w_f;

        // reset values
        do_reset();
        check("rst ar_ready", ar_ready, 1);
        check("rst aw_ready", aw_ready, 1);
        check("rst w_ready", w_ready, 1);
        check("rst req_valid", req_valid, 0);
        check("rst data_valid", data_valid, 0);
        check("rst data_last", data_last, 0);
        check("rst proto_err", proto_err, 0);
        check("rst req_addr", req_addr, 0);
        check("rst data", data, 0);

        // single read: AR handshake in N, request visible in N+2 for one cycle
        req_ready = 1'b1; data_ready = 1'b1;
        ar_valid = 1'b1; ar_addr = 32'h1000; ar_id = 4'd3; ar_user = 4'hA;
        tick();
        ar_valid = 1'b0;
        check("rd N+1 req_valid", req_valid, 0);
        check("rd N+1 ar_ready", ar_ready, 0);
        tick();
        check("rd req_valid", req_valid, 1);
        check("rd req_write", req_write, 0);
        check("rd req_addr", req_addr, 32'h1000);
        check("rd req_id", req_id, 3);
        check("rd req_user", req_user, 4'hA);
        tick();
        check("rd one cycle", req_valid, 0);
        check("rd ar_ready back", ar_ready, 1);

        // write with W ahead of AW
        do_reset();
        req_ready = 1'b1; data_ready = 1'b1;
        for (int k = 1; k <= 4; k++) w_beat(64'(k * 'h11), k == 4);
        aw_valid = 1'b1; aw_addr = 32'h2000; aw_id = 4'd5; aw_user = 4'h6;
        tick();
        aw_valid = 1'b0;
        check("wr N+1 req_valid", req_valid, 0);
        tick();
        check("wr req_valid", req_valid, 1);
        check("wr req_write", req_write, 1);
        check("wr req_addr", req_addr, 32'h2000);
        check("wr req_id", req_id, 5);
        check("wr data_valid early", data_valid, 0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("wr data_valid", data_valid, 1);
            check("wr data", data, 64'(k * 'h11));
            check("wr strb", strb, 8'hFF);
            check("wr data_last", data_last, k == 4);
            tick();
        end
        check("wr burst done", data_valid, 0);
        check("wr req idle", req_valid, 0);

        // tie fairness: two reads and two writes queued from reset
        do_reset();
        req_ready = 1'b1; data_ready = 1'b1;
        for (int k = 0; k < 8; k++) w_beat(64'('hA0 + k), k == 3 || k == 7);
        check("fair bursts_avail", 64'(dut.bursts_avail), 2);
        ar_i = 0; aw_i = 0; g = 0;
        for (int c = 0; c < 100 && g < 4; c++) begin
            ar_valid = ar_i < 2; ar_addr = 32'h3000 + 32'(ar_i * 16); ar_id = 4'(ar_i);
            aw_valid = aw_i < 2; aw_addr = 32'h4000 + 32'(aw_i * 16); aw_id = 4'(aw_i);
            if (req_valid && req_ready) begin
                gw[g] = req_write;
                ga[g] = req_addr;
                g++;
            end
            a_f = int'(ar_valid && ar_ready);
            w_f = int'(aw_valid && aw_ready);
            tick();
            ar_i += a_f;
            aw_i += w_f;
        end
        ar_valid = 1'b0; aw_valid = 1'b0;
        check("fair grant count", 64'(g), 4);
        if (g == 4) begin
            check("fair grant0 type", gw[0], 0);
            check("fair grant1 type", gw[1], 1);
            check("fair grant2 type", gw[2], 0);
            check("fair grant3 type", gw[3], 1);
            check("fair grant0 addr", ga[0], 32'h3000);
            check("fair grant1 addr", ga[1], 32'h4000);
            check("fair grant2 addr", ga[2], 32'h3010);
            check("fair grant3 addr", ga[3], 32'h4010);
        end
        repeat (8) tick();

        // backpressure on RD_REQ with a second AR waiting
        do_reset();
        req_ready = 1'b0; data_ready = 1'b1;
        ar_valid = 1'b1; ar_addr = 32'h5000; ar_id = 4'd7;
        tick();
        ar_addr = 32'h5100; ar_id = 4'd8;
        check("bp ar_ready held", ar_ready, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp req_valid", req_valid, 1);
            check("bp req_addr stable", req_addr, 32'h5000);
            check("bp ar_ready", ar_ready, 0);
            tick();
        end
        req_ready = 1'b1;
        check("bp release addr", req_addr, 32'h5000);
        check("bp release id", req_id, 7);
        tick();
        check("bp after issue", req_valid, 0);
        check("bp ar_ready free", ar_ready, 1);
        tick();
        ar_valid = 1'b0;
        tick();
        check("bp second req", req_valid, 1);
        check("bp second addr", req_addr, 32'h5100);
        check("bp second id", req_id, 8);
        tick();

        // FIFO full with no AW, then drain one burst
        do_reset();
        req_ready = 1'b1; data_ready = 1'b1;
        for (int k = 0; k < 8; k++) w_beat(64'('h100 + k), k == 3 || k == 7);
        check("full w_ready", w_ready, 0);
        check("full bursts_avail", 64'(dut.bursts_avail), 2);
        aw_valid = 1'b1; aw_addr = 32'h6000; aw_id = 4'd2;
        tick();
        aw_valid = 1'b0;
        tick();
        check("full req_addr", req_addr, 32'h6000);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("full data", data, 64'('h100 + k));
            check("full data_last", data_last, k == 3);
            tick();
        end
        check("full drained data_valid", data_valid, 0);
        check("full w_ready again", w_ready, 1);
        check("full bursts_avail after", 64'(dut.bursts_avail), 1);

        // protocol errors: short burst, then long burst
        do_reset();
        req_ready = 1'b1; data_ready = 1'b1;
        check("perr clear", proto_err, 0);
        w_beat(64'h1, 1'b0);
        w_beat(64'h2, 1'b0);
        check("perr before last", proto_err, 0);
        w_beat(64'h3, 1'b1);
        check("perr short burst", proto_err, 1);
        ar_send(32'h7000, 4'd1);
        repeat (3) tick();
        for (int k = 0; k < 4; k++) w_beat(64'('h10 + k), k == 3);
        check("perr sticky", proto_err, 1);
        do_reset();
        check("perr cleared by rst", proto_err, 0);
        for (int k = 0; k < 3; k++) w_beat(64'('h20 + k), 1'b0);
        check("perr 3 beats no last", proto_err, 0);
        w_beat(64'h23, 1'b0);
        check("perr missing last", proto_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
